// File: rtl/snax_hwpe_periph_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | snax_hwpe_periph_regfile: HWPE peripheral-port responder holding config  |
// | registers and a trigger/status FSM. Optional cycle counter at word 2     |
// | under SNAX_HWPE_PERIPH_REGFILE_PERF_EN.                  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module snax_hwpe_periph_regfile #(
  parameter int NumRegs      = 8,
  parameter int IdWidth      = 5,
  parameter int AddrIdxWidth = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   periph_req_i,
  output logic                   periph_gnt_o,
  input  logic [31:0]            periph_add_i,
  input  logic                   periph_wen_i,
  input  logic [3:0]             periph_be_i,
  input  logic [31:0]            periph_data_i,
  input  logic [IdWidth-1:0]     periph_id_i,
  output logic                   periph_r_valid_o,
  output logic [31:0]            periph_r_data_o,
  output logic [IdWidth-1:0]     periph_r_id_o,
  output logic                   start_o,
  output logic                   busy_o,
  input  logic                   done_i,
  output logic [NumRegs*32-1:0]  cfg_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    START   = 2'd1,
    RUNNING = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [31:0]          cfg_q [NumRegs];
  logic [31:0]          cfg_d [NumRegs];
  logic                 done_q, done_d;
  logic                 r_valid_q, r_valid_d;
  logic [31:0]          r_data_q, r_data_d;
  logic [IdWidth-1:0]   r_id_q, r_id_d;

  logic [AddrIdxWidth-1:0] idx;
  logic                 accept, wr_acc, rd_acc, trigger;
  logic [31:0]          rdata, perf_rd;
  logic                 unused_add;

  // Holding off the grant while a response is out stops a master that keeps
  // req high until r_valid from having its read accepted twice.
  assign periph_gnt_o = periph_req_i & ~r_valid_q;
  assign accept       = periph_req_i & periph_gnt_o;
  assign idx          = periph_add_i[AddrIdxWidth+1:2];
  assign wr_acc       = accept & ~periph_wen_i;
  assign rd_acc       = accept & periph_wen_i;
  assign trigger      = wr_acc & (state_q == IDLE) & (idx == '0)
                        & periph_be_i[0] & periph_data_i[0];
  assign unused_add   = ^{periph_add_i[31:AddrIdxWidth+2], periph_add_i[1:0]};

`ifdef SNAX_HWPE_PERIPH_REGFILE_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (trigger) begin
      perf_d = '0;
    end else if (state_q != IDLE) begin
      perf_d = perf_q + 32'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_rd = perf_q;
`else
  assign perf_rd = '0;
`endif

  // A completion in the same cycle as a W1C clear must leave the flag set.
  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    if (wr_acc && (idx == AddrIdxWidth'(1)) && periph_be_i[0] && periph_data_i[1]) begin
      done_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = START;
          done_d  = 1'b0;
        end
      end
      START:   state_d = RUNNING;
      RUNNING: begin
        if (done_i) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    for (int k = 0; k < NumRegs; k++) begin
      cfg_d[k] = cfg_q[k];
      if (wr_acc && (state_q == IDLE) && (idx == AddrIdxWidth'(k + 4))) begin
        for (int b = 0; b < 4; b++) begin
          if (periph_be_i[b]) begin
            cfg_d[k][8*b +: 8] = periph_data_i[8*b +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (idx == AddrIdxWidth'(1)) begin
      rdata[1:0] = {done_q, state_q != IDLE};
    end else if (idx == AddrIdxWidth'(2)) begin
      rdata = perf_rd;
    end
    for (int k = 0; k < NumRegs; k++) begin
      if (idx == AddrIdxWidth'(k + 4)) begin
        rdata = cfg_q[k];
      end
    end
    r_valid_d = rd_acc;
    r_data_d  = rd_acc ? rdata : '0;
    r_id_d    = rd_acc ? periph_id_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      done_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      r_id_q    <= '0;
      for (int k = 0; k < NumRegs; k++) begin
        cfg_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      r_id_q    <= r_id_d;
      for (int k = 0; k < NumRegs; k++) begin
        cfg_q[k] <= cfg_d[k];
      end
    end
  end

  for (genvar k = 0; k < NumRegs; k++) begin : g_cfg
    assign cfg_o[32*k +: 32] = cfg_q[k];
  end

  assign periph_r_valid_o = r_valid_q;
  assign periph_r_data_o  = r_data_q;
  assign periph_r_id_o    = r_id_q;
  assign start_o          = (state_q == START);
  assign busy_o           = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_snax_hwpe_periph_regfile.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_snax_hwpe_periph_regfile: directed and random stimulus against a      |
// | transaction-level model of the register file.            Revision: 1.0   |
// +--------------------------------------------------------------------------+
module tb_snax_hwpe_periph_regfile;
  localparam int NR = 8;
  localparam int IW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, wen, done_in;
  logic [31:0]   addr, wdata;
  logic [3:0]    be;
  logic [IW-1:0] id;
  logic          gnt, r_valid, start_o, busy_o;
  logic [31:0]   r_data;
  logic [IW-1:0] r_id;
  logic [NR*32-1:0] cfg_o;

  int total = 0;
  int bad   = 0;

  // Reference model state, seen as "what the current cycle must show".
  logic [31:0]   m_cfg [NR];
  logic          m_done, m_busy, m_start;
  logic [31:0]   m_perf;
  logic          m_rvalid;
  logic [31:0]   m_rdata;
  logic [IW-1:0] m_rid;

  logic          s_start, s_busy, s_rvalid;
  logic [31:0]   last_rdata;
  logic [IW-1:0] last_rid;
  logic [31:0]   perf_exp;

  snax_hwpe_periph_regfile #(.NumRegs(NR), .IdWidth(IW), .AddrIdxWidth(6)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .periph_req_i(req), .periph_gnt_o(gnt), .periph_add_i(addr),
    .periph_wen_i(wen), .periph_be_i(be), .periph_data_i(wdata),
    .periph_id_i(id), .periph_r_valid_o(r_valid), .periph_r_data_o(r_data),
    .periph_r_id_o(r_id), .start_o(start_o), .busy_o(busy_o),
    .done_i(done_in), .cfg_o(cfg_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_cfg[k] = '0;
    m_done = 0; m_busy = 0; m_start = 0; m_perf = '0;
    m_rvalid = 0; m_rdata = '0; m_rid = '0;
  endtask

  function automatic logic [31:0] model_read(input int i);
    if (i == 1) return {30'd0, m_done, m_busy};
`ifdef SNAX_HWPE_PERIPH_REGFILE_PERF_EN
    if (i == 2) return m_perf;
`endif
    if (i >= 4 && i < 4 + NR) return m_cfg[i-4];
    return 32'd0;
  endfunction

  task automatic model_step();
    int i;
    logic acc, fire, was_busy, was_running, n_rvalid;
    logic [31:0] n_rdata;
    logic [IW-1:0] n_rid;
    if (!rst_n) begin
      model_reset();
    end else begin
      acc         = req && !m_rvalid;
      i           = int'(addr[7:2]);
      n_rvalid    = acc && wen;
      n_rdata     = n_rvalid ? model_read(i) : 32'd0;
      n_rid       = n_rvalid ? id : '0;
      was_busy    = m_busy;
      was_running = m_busy && !m_start;
      fire        = 0;
      if (acc && !wen) begin
        if (i == 0 && !was_busy && be[0] && wdata[0]) fire = 1;
        if (i == 1 && be[0] && wdata[1]) m_done = 0;
        if (i >= 4 && i < 4 + NR && !was_busy)
          for (int b = 0; b < 4; b++)
            if (be[b]) m_cfg[i-4][8*b +: 8] = wdata[8*b +: 8];
      end
      if (was_running && done_in) begin
        m_busy = 0;
        m_done = 1;
      end
      m_start = 0;
      if (fire) begin
        m_busy = 1; m_start = 1; m_done = 0; m_perf = '0;
      end else if (was_busy) begin
        m_perf = m_perf + 32'd1;
      end
      m_rvalid = n_rvalid;
      m_rdata  = n_rdata;
      m_rid    = n_rid;
    end
  endtask

  task automatic cycle();
    logic [255:0] exp_cfg;
    @(negedge clk);
    s_start  = start_o;
    s_busy   = busy_o;
    s_rvalid = r_valid;
    check_eq("gnt", gnt, req & ~m_rvalid);
    check_eq("start", start_o, m_start);
    check_eq("busy", busy_o, m_busy);
    check_eq("r_valid", r_valid, m_rvalid);
    check_eq("r_data", r_data, m_rdata);
    if (m_rvalid) begin
      check_eq("r_id", r_id, m_rid);
      last_rdata = r_data;
      last_rid   = r_id;
    end
    exp_cfg = '0;
    for (int k = 0; k < NR; k++) exp_cfg[32*k +: 32] = m_cfg[k];
    check_eq("cfg", cfg_o, exp_cfg);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    req = 1; wen = 0; addr = a; wdata = d; be = b;
    cycle();
    req = 0;
  endtask

  task automatic rd(input logic [31:0] a, input logic [IW-1:0] i);
    int n = 0;
    last_rdata = 32'hDEAD_BEEF;
    req = 1; wen = 1; addr = a; id = i;
    cycle(); n += int'(s_rvalid);
    cycle(); n += int'(s_rvalid);
    req = 0; wen = 0;
    cycle(); n += int'(s_rvalid);
    check_eq("rd_pulses", n, 1);
  endtask

  initial begin
    rst_n = 0; req = 0; wen = 0; done_in = 0;
    addr = '0; wdata = '0; be = '0; id = '0;
    model_reset();
    cycle();
    check_eq("rst_busy", busy_o, 0);
    check_eq("rst_cfg", cfg_o, 0);
    cycle();
    rst_n = 1;
    cycle();

    wr(32'h10, 32'hA5A5_1234, 4'hF);
    rd(32'h10, 5'd3);
    check_eq("cfg4_rd", last_rdata, 32'hA5A5_1234);
    check_eq("cfg4_id", last_rid, 5'd3);
    check_eq("cfg4_out", cfg_o[31:0], 32'hA5A5_1234);

    wr(32'h14, 32'h0000_BB00, 4'b0010);
    rd(32'h14, 5'd7);
    check_eq("cfg5_rd", last_rdata, 32'h0000_BB00);
    check_eq("cfg5_out", cfg_o[63:32], 32'h0000_BB00);

    wr(32'h0, 32'h1, 4'hF);
    cycle();
    check_eq("start_pulse", s_start, 1);
    check_eq("busy_run", s_busy, 1);
    rd(32'h4, 5'd1);
    check_eq("status_busy", last_rdata, 32'h1);
    wr(32'h10, 32'hFFFF_FFFF, 4'hF);
    wr(32'h0, 32'h1, 4'hF);
    cycle();
    check_eq("cfg_locked", cfg_o[31:0], 32'hA5A5_1234);
    check_eq("no_restart", s_start, 0);
    done_in = 1; cycle(); done_in = 0;
    cycle();
    check_eq("busy_done", s_busy, 0);
    rd(32'h4, 5'd2);
    check_eq("status_done", last_rdata, 32'h2);
    wr(32'h4, 32'h2, 4'hF);
    rd(32'h4, 5'd4);
    check_eq("status_w1c", last_rdata, 32'h0);
    done_in = 1; cycle(); done_in = 0;
    rd(32'h4, 5'd5);
    check_eq("idle_done", last_rdata, 32'h0);

    wr(32'h0, 32'h1, 4'hF);
    cycle(); cycle();
    done_in = 1;
    wr(32'h4, 32'h2, 4'hF);
    done_in = 0;
    rd(32'h4, 5'd6);
    check_eq("set_wins", last_rdata, 32'h2);

    wr(32'h0, 32'h1, 4'hF);
    cycle();
    for (int k = 0; k < 9; k++) cycle();
    done_in = 1; cycle(); done_in = 0;
    rd(32'h8, 5'd8);
`ifdef SNAX_HWPE_PERIPH_REGFILE_PERF_EN
    perf_exp = 32'd11;
`else
    perf_exp = 32'd0;
`endif
    check_eq("perf", last_rdata, perf_exp);

    wr(32'h0, 32'h1, 4'hF);
    rst_n = 0;
    #1;
    check_eq("arst_busy", busy_o, 0);
    check_eq("arst_start", start_o, 0);
    check_eq("arst_rvalid", r_valid, 0);
    check_eq("arst_cfg", cfg_o, 0);
    model_reset();
    cycle();
    rst_n = 1;
    cycle();
    rd(32'h4, 5'd9);
    check_eq("arst_status", last_rdata, 32'h0);

    for (int c = 0; c < 1500; c++) begin
      req     = ($urandom_range(0, 3) != 0);
      wen     = $urandom_range(0, 1) == 1;
      addr    = {24'd0, 6'($urandom_range(0, 17)), 2'b00};
      wdata   = $urandom;
      be      = 4'($urandom_range(0, 15));
      id      = IW'($urandom_range(0, 31));
      done_in = ($urandom_range(0, 5) == 0);
      cycle();
    end
    req = 0; done_in = 0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
